// File: rtl/vga_timing_prog.sv
// Programmable VGA/DVI timing generator. Timing and polarity inputs are captured
// into shadow registers only on the last pixel of a frame, so mode changes never tear.
module vga_timing_prog #(
    parameter int unsigned HW     = 11,
    parameter int unsigned VW     = 10,
    parameter int unsigned FCW    = 8,
    parameter int unsigned D_HACT = 640,
    parameter int unsigned D_HFP  = 16,
    parameter int unsigned D_HSY  = 96,
    parameter int unsigned D_HBP  = 48,
    parameter int unsigned D_VACT = 480,
    parameter int unsigned D_VFP  = 10,
    parameter int unsigned D_VSY  = 2,
    parameter int unsigned D_VBP  = 33,
    parameter bit          D_HPOL = 1'b0,
    parameter bit          D_VPOL = 1'b0
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           advance_i,
    input  logic [HW-1:0]  cfg_hact_i,
    input  logic [HW-1:0]  cfg_hfp_i,
    input  logic [HW-1:0]  cfg_hsy_i,
    input  logic [HW-1:0]  cfg_hbp_i,
    input  logic [VW-1:0]  cfg_vact_i,
    input  logic [VW-1:0]  cfg_vfp_i,
    input  logic [VW-1:0]  cfg_vsy_i,
    input  logic [VW-1:0]  cfg_vbp_i,
    input  logic           cfg_hpol_i,
    input  logic           cfg_vpol_i,
    input  logic [VW-1:0]  irq_line_i,
    output logic [HW-1:0]  x_o,
    output logic [VW-1:0]  y_o,
    output logic           blank_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           line_start_o,
    output logic           frame_start_o,
    output logic           line_irq_o,
    output logic           cfg_reject_o,
    output logic [FCW-1:0] frame_count_o
);

    localparam int unsigned HS = HW + 2;
    localparam int unsigned VS = VW + 2;
    localparam logic [HS-1:0] HMAX = HS'(1) << HW;
    localparam logic [VS-1:0] VMAX = VS'(1) << VW;

    logic [HW-1:0]  x_q, x_d;
    logic [VW-1:0]  y_q, y_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic           reject_q, reject_d;

    logic [HW-1:0]  s_hact_q, s_hfp_q, s_hsy_q, s_hbp_q;
    logic [HW-1:0]  s_hact_d, s_hfp_d, s_hsy_d, s_hbp_d;
    logic [VW-1:0]  s_vact_q, s_vfp_q, s_vsy_q, s_vbp_q;
    logic [VW-1:0]  s_vact_d, s_vfp_d, s_vsy_d, s_vbp_d;
    logic           s_hpol_q, s_vpol_q, s_hpol_d, s_vpol_d;

    logic [HS-1:0]  htot, hsy_start, hsy_end, x_ext, req_htot;
    logic [VS-1:0]  vtot, vsy_start, vsy_end, y_ext, req_vtot;
    logic           x_last, y_last, in_hsync, in_vsync;
    logic           line_start, frame_start, cfg_ok;
    logic [VW-1:0]  y_nxt;

    // Region boundaries are summed two bits wider so full-range fields never wrap.
    always_comb begin
        x_ext     = HS'(x_q);
        y_ext     = VS'(y_q);
        hsy_start = HS'(s_hact_q) + HS'(s_hfp_q);
        hsy_end   = hsy_start + HS'(s_hsy_q);
        htot      = hsy_end + HS'(s_hbp_q);
        vsy_start = VS'(s_vact_q) + VS'(s_vfp_q);
        vsy_end   = vsy_start + VS'(s_vsy_q);
        vtot      = vsy_end + VS'(s_vbp_q);
        req_htot  = HS'(cfg_hact_i) + HS'(cfg_hfp_i) + HS'(cfg_hsy_i) + HS'(cfg_hbp_i);
        req_vtot  = VS'(cfg_vact_i) + VS'(cfg_vfp_i) + VS'(cfg_vsy_i) + VS'(cfg_vbp_i);
    end

    assign x_last      = (x_ext == htot - HS'(1));
    assign y_last      = (y_ext == vtot - VS'(1));
    assign in_hsync    = (x_ext >= hsy_start) && (x_ext < hsy_end);
    assign in_vsync    = (y_ext >= vsy_start) && (y_ext < vsy_end);
    assign y_nxt       = y_last ? '0 : y_q + VW'(1);
    assign line_start  = advance_i && x_last;
    assign frame_start = line_start && y_last;

    assign cfg_ok = (cfg_hact_i != '0) && (cfg_hsy_i != '0) &&
                    (cfg_vact_i != '0) && (cfg_vsy_i != '0) &&
                    (req_htot <= HMAX) && (req_vtot <= VMAX);

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        fc_d     = fc_q;
        reject_d = 1'b0;
        s_hact_d = s_hact_q;
        s_hfp_d  = s_hfp_q;
        s_hsy_d  = s_hsy_q;
        s_hbp_d  = s_hbp_q;
        s_vact_d = s_vact_q;
        s_vfp_d  = s_vfp_q;
        s_vsy_d  = s_vsy_q;
        s_vbp_d  = s_vbp_q;
        s_hpol_d = s_hpol_q;
        s_vpol_d = s_vpol_q;
        if (advance_i) begin
            x_d = x_last ? '0 : x_q + HW'(1);
            if (x_last) begin
                y_d = y_nxt;
            end
        end
        if (frame_start) begin
            fc_d = fc_q + FCW'(1);
            if (cfg_ok) begin
                s_hact_d = cfg_hact_i;
                s_hfp_d  = cfg_hfp_i;
                s_hsy_d  = cfg_hsy_i;
                s_hbp_d  = cfg_hbp_i;
                s_vact_d = cfg_vact_i;
                s_vfp_d  = cfg_vfp_i;
                s_vsy_d  = cfg_vsy_i;
                s_vbp_d  = cfg_vbp_i;
                s_hpol_d = cfg_hpol_i;
                s_vpol_d = cfg_vpol_i;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_q      <= '0;
            y_q      <= '0;
            fc_q     <= '0;
            reject_q <= 1'b0;
            s_hact_q <= HW'(D_HACT);
            s_hfp_q  <= HW'(D_HFP);
            s_hsy_q  <= HW'(D_HSY);
            s_hbp_q  <= HW'(D_HBP);
            s_vact_q <= VW'(D_VACT);
            s_vfp_q  <= VW'(D_VFP);
            s_vsy_q  <= VW'(D_VSY);
            s_vbp_q  <= VW'(D_VBP);
            s_hpol_q <= D_HPOL;
            s_vpol_q <= D_VPOL;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            fc_q     <= fc_d;
            reject_q <= reject_d;
            s_hact_q <= s_hact_d;
            s_hfp_q  <= s_hfp_d;
            s_hsy_q  <= s_hsy_d;
            s_hbp_q  <= s_hbp_d;
            s_vact_q <= s_vact_d;
            s_vfp_q  <= s_vfp_d;
            s_vsy_q  <= s_vsy_d;
            s_vbp_q  <= s_vbp_d;
            s_hpol_q <= s_hpol_d;
            s_vpol_q <= s_vpol_d;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign blank_o       = !((x_q < s_hact_q) && (y_q < s_vact_q));
    assign hsync_o       = in_hsync ? s_hpol_q : ~s_hpol_q;
    assign vsync_o       = in_vsync ? s_vpol_q : ~s_vpol_q;
    assign line_start_o  = line_start;
    assign frame_start_o = frame_start;
    // y_nxt is always below VTOT, so an out-of-range irq_line can never match.
    assign line_irq_o    = line_start && (y_nxt == irq_line_i);
    assign cfg_reject_o  = reject_q;
    assign frame_count_o = fc_q;

endmodule
